// File: rtl/com_out_driver.sv
// Active-low command output driver: per-channel minimum-on-time stretcher with
// global enable interlock and sticky readback-mismatch fault detection.
module com_out_driver #(
   parameter int NUM_SIGNALS = 16,
   parameter int HOLD_WIDTH  = 4,
   parameter int CHECK_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   sclr_n,
   input  logic [NUM_SIGNALS-1:0] cmd,
   input  logic                   enable,
   input  logic [NUM_SIGNALS-1:0] fb,
   input  logic                   fault_clr,
   output logic [NUM_SIGNALS-1:0] out,
   output logic [NUM_SIGNALS-1:0] fault,
   output logic                   busy
);

   localparam logic [HOLD_WIDTH-1:0]  HOLD_MAX  = {HOLD_WIDTH{1'b1}};
   localparam logic [CHECK_WIDTH-1:0] CHECK_MAX = {CHECK_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e                 state_q [NUM_SIGNALS];
   state_e                 state_d [NUM_SIGNALS];
   logic [HOLD_WIDTH-1:0]  hold_q  [NUM_SIGNALS];
   logic [HOLD_WIDTH-1:0]  hold_d  [NUM_SIGNALS];
   logic [CHECK_WIDTH-1:0] mm_q    [NUM_SIGNALS];
   logic [CHECK_WIDTH-1:0] mm_d    [NUM_SIGNALS];
   logic [NUM_SIGNALS-1:0] out_q, out_d;
   logic [NUM_SIGNALS-1:0] fault_q, fault_d;
   logic                   busy_q, busy_d;

   // Per-channel state machine: the hold counter keeps running when HOLD
   // returns to ON, so a retrigger never extends the minimum active time.
   always_comb begin
      for (int i = 0; i < NUM_SIGNALS; i++) begin
         logic [HOLD_WIDTH-1:0] hold_dec;
         hold_dec   = (hold_q[i] == '0) ? '0 : hold_q[i] - 1'b1;
         state_d[i] = state_q[i];
         hold_d[i]  = hold_q[i];
         if (!enable) begin
            state_d[i] = ST_OFF;
            hold_d[i]  = '0;
         end else begin
            case (state_q[i])
               ST_OFF: begin
                  if (cmd[i]) begin
                     state_d[i] = ST_ON;
                     hold_d[i]  = HOLD_MAX;
                  end
               end
               ST_ON: begin
                  hold_d[i] = hold_dec;
                  if (!cmd[i]) begin
                     state_d[i] = (hold_q[i] == '0) ? ST_OFF : ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  hold_d[i] = hold_dec;
                  if (cmd[i]) begin
                     state_d[i] = ST_ON;
                  end else if (hold_q[i] == '0) begin
                     state_d[i] = ST_OFF;
                  end
               end
               default: begin
                  state_d[i] = ST_OFF;
                  hold_d[i]  = '0;
               end
            endcase
         end
      end
   end

   // Outputs and mismatch tracking; a toggle restarts the settle window.
   always_comb begin
      busy_d = 1'b0;
      for (int i = 0; i < NUM_SIGNALS; i++) begin
         logic toggle;
         logic mismatch;
         logic set;
         out_d[i] = (state_d[i] == ST_OFF);
         busy_d   = busy_d | (state_d[i] != ST_OFF);
         toggle   = out_d[i] ^ out_q[i];
         mismatch = fb[i] ^ out_q[i];
         set      = mismatch && !toggle && (mm_q[i] == CHECK_MAX - 1'b1);
         if (toggle || !mismatch) begin
            mm_d[i] = '0;
         end else if (mm_q[i] != CHECK_MAX) begin
            mm_d[i] = mm_q[i] + 1'b1;
         end else begin
            mm_d[i] = mm_q[i];
         end
         if (fault_clr) begin
            mm_d[i] = '0;
         end
         fault_d[i] = set | (fault_q[i] & ~fault_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         for (int i = 0; i < NUM_SIGNALS; i++) begin
            state_q[i] <= ST_OFF;
            hold_q[i]  <= '0;
            mm_q[i]    <= '0;
         end
         out_q   <= '1;
         fault_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SIGNALS; i++) begin
            state_q[i] <= state_d[i];
            hold_q[i]  <= hold_d[i];
            mm_q[i]    <= mm_d[i];
         end
         out_q   <= out_d;
         fault_q <= fault_d;
         busy_q  <= busy_d;
      end
   end

   assign out   = out_q;
   assign fault = fault_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_com_out_driver.sv
// Bench for com_out_driver: directed scenarios plus random traffic, checked
// every cycle against a timestamp-based behavioural model.
module tb_com_out_driver;

   localparam int N         = 16;
   localparam int HOLD_MAX  = 15;
   localparam int CHECK_MAX = 7;

   logic         clk;
   logic         sclr_n;
   logic [N-1:0] cmd;
   logic         enable;
   logic [N-1:0] fb;
   logic         fault_clr;
   logic [N-1:0] out;
   logic [N-1:0] fault;
   logic         busy;

   com_out_driver #(.NUM_SIGNALS(N), .HOLD_WIDTH(4), .CHECK_WIDTH(3)) dut (
      .clk       (clk),
      .sclr_n    (sclr_n),
      .cmd       (cmd),
      .enable    (enable),
      .fb        (fb),
      .fault_clr (fault_clr),
      .out       (out),
      .fault     (fault),
      .busy      (busy)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // stimulus variables applied by tick()
   logic         rst_v    = 1'b0;
   logic         en_v     = 1'b1;
   logic         clr_v    = 1'b0;
   logic [N-1:0] cmd_v    = '0;
   logic [N-1:0] fb_force = '0;
   logic [N-1:0] fb_v     = '1;

   // model: a channel is active while commanded, or until the earliest
   // cycle at which its minimum active time (stamped at activation) ends
   bit           m_act [N];
   int           m_rel [N];
   int           m_run [N];
   logic [N-1:0] m_fault = '0;
   int           cyc     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] m_out();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = !m_act[i];
      return r;
   endfunction

   function automatic logic m_busy();
      logic b;
      b = 1'b0;
      for (int i = 0; i < N; i++) b = b | m_act[i];
      return b;
   endfunction

   task automatic model_edge();
      logic [N-1:0] o_old;
      bit           na;
      bit           set;
      cyc++;
      o_old = m_out();
      for (int i = 0; i < N; i++) begin
         if (!rst_v) begin
            m_act[i]   = 1'b0;
            m_run[i]   = 0;
            m_fault[i] = 1'b0;
         end else begin
            if (!en_v) begin
               na = 1'b0;
            end else if (cmd_v[i]) begin
               if (!m_act[i]) m_rel[i] = cyc + HOLD_MAX + 1;
               na = 1'b1;
            end else begin
               na = m_act[i] && (cyc < m_rel[i]);
            end
            if ((!na) != o_old[i] || fb_v[i] == o_old[i]) m_run[i] = 0;
            else m_run[i] = m_run[i] + 1;
            set = (m_run[i] == CHECK_MAX);
            if (clr_v) begin
               m_fault[i] = set;
               m_run[i]   = 0;
            end else if (set) begin
               m_fault[i] = 1'b1;
            end
            m_act[i] = na;
         end
      end
   endtask

   // driver: apply inputs on the falling edge, check #1 after the rising edge
   task automatic tick();
      @(negedge clk);
      fb_v      = m_out() ^ fb_force;
      sclr_n    = rst_v;
      enable    = en_v;
      fault_clr = clr_v;
      cmd       = cmd_v;
      fb        = fb_v;
      @(posedge clk);
      model_edge();
      #1;
      check("out", out, m_out());
      check("fault", fault, m_fault);
      check("busy", busy, m_busy());
   endtask

   int n;
   int last;

   initial begin
      sclr_n = 1'b0; enable = 1'b1; fault_clr = 1'b0; cmd = '0; fb = '1;
      for (int i = 0; i < N; i++) begin
         m_act[i] = 1'b0; m_rel[i] = 0; m_run[i] = 0;
      end

      // reset holds everything off even with all commands asserted
      rst_v = 1'b0; cmd_v = '1;
      repeat (3) begin
         tick();
         check("rst_out", out, 16'hFFFF);
         check("rst_busy", busy, 0);
      end
      rst_v = 1'b1;
      tick();
      check("rst_release", out, 16'h0000);
      cmd_v = '0;
      repeat (20) tick();

      // one-cycle pulse stretched to HOLD_MAX + 1 cycles
      n = 0;
      cmd_v = 16'h0001; tick(); if (!out[0]) n++;
      cmd_v = '0;
      repeat (25) begin tick(); if (!out[0]) n++; end
      check("min_pulse", n, 16);

      // long command, one-cycle latency on both edges
      n = 0;
      cmd_v = 16'h0002;
      repeat (40) begin tick(); if (!out[1]) n++; end
      cmd_v = '0;
      repeat (20) begin tick(); if (!out[1]) n++; end
      check("long_cmd", n, 40);

      // retrigger while in HOLD keeps the output continuously low
      n = 0; last = -1;
      for (int k = 0; k < 60; k++) begin
         cmd_v = (k == 0 || (k >= 6 && k < 36)) ? 16'h0004 : 16'h0000;
         tick();
         if (!out[2]) begin n++; last = k; end
      end
      check("retrig_len", n, 36);
      check("retrig_last", last, 35);

      // enable interlock and fresh hold on re-enable
      cmd_v = 16'h0008;
      repeat (3) tick();
      en_v = 1'b0; tick();
      check("interlock_off", out[3], 1);
      en_v = 1'b1; tick();
      check("interlock_on", out[3], 0);
      n = 1;
      cmd_v = '0;
      repeat (25) begin tick(); if (!out[3]) n++; end
      check("interlock_hold", n, 16);

      // short mismatch is tolerated, persistent mismatch faults after 7
      cmd_v = 16'h0010;
      repeat (3) tick();
      fb_force = 16'h0010;
      repeat (6) tick();
      fb_force = '0;
      repeat (3) tick();
      check("short_mm", fault[4], 0);
      fb_force = 16'h0010;
      n = 0;
      do begin tick(); n++; end while (!fault[4] && n < 20);
      check("fault_delay", n, 7);

      // clear while mismatch persists, then re-fault
      clr_v = 1'b1; tick(); clr_v = 1'b0;
      check("clr_fault4", fault[4], 0);
      n = 0;
      do begin tick(); n++; end while (!fault[4] && n < 20);
      check("refault_delay", n, 7);

      // set wins over a simultaneous clear
      cmd_v = 16'h0030;
      repeat (3) tick();
      fb_force = 16'h0030;
      repeat (6) tick();
      clr_v = 1'b1; tick(); clr_v = 1'b0;
      check("set_wins5", fault[5], 1);
      check("clr_wins4", fault[4], 0);
      fb_force = '0; cmd_v = '0;
      clr_v = 1'b1; tick(); clr_v = 1'b0;
      repeat (20) tick();

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         rst_v    = ($urandom_range(0, 199) != 0);
         en_v     = ($urandom_range(0, 29) != 0);
         clr_v    = ($urandom_range(0, 39) == 0);
         cmd_v    = cmd_v ^ N'($urandom & $urandom & $urandom);
         fb_force = fb_force ^ N'($urandom & $urandom & $urandom & $urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
